// File: rtl/gem_fiber_pkg.sv
// Shared constants, FSM state type and K-code helpers for the GEM fiber RX deframer.
package gem_fiber_pkg;

  localparam logic [7:0]  K_BC      = 8'hBC;
  localparam logic [7:0]  K_F7      = 8'hF7;
  localparam logic [7:0]  K_FB      = 8'hFB;
  localparam logic [7:0]  K_FD      = 8'hFD;
  localparam logic [7:0]  K_FC      = 8'hFC;
  localparam logic [31:0] IDLE_WORD = 32'h50BC50BC;
  localparam logic [3:0]  ISK_A     = 4'b0000;
  localparam logic [3:0]  ISK_B     = 4'b0001;
  localparam logic [3:0]  ISK_IDLE  = 4'b0101;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // Bunch-sequence index carried by a separator; FC has no index of its own.
  function automatic logic [1:0] k_to_idx(input logic [7:0] k);
    logic [1:0] idx;
    case (k)
      K_F7:    idx = 2'd1;
      K_FB:    idx = 2'd2;
      K_FD:    idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic is_sep(input logic [7:0] k);
    return (k == K_BC) || (k == K_F7) || (k == K_FB) || (k == K_FD) || (k == K_FC);
  endfunction

endpackage

// File: rtl/gem_fiber_rx_deframer_if.sv
// GTX RX word stream into the deframer and reassembled cluster frames out of it.
interface gem_fiber_rx_deframer_if;
  logic [31:0] RX_DATA;
  logic [3:0]  RX_ISK;
  logic        RX_READY;
  logic [55:0] GEM_DATA;
  logic        GEM_OVERFLOW;
  logic        GEM_VALID;
  logic [1:0]  BX_SEQ;

  // master: GTX wrapper / cluster consumer side; slave: the deframer
  modport master (
    output RX_DATA, RX_ISK, RX_READY,
    input  GEM_DATA, GEM_OVERFLOW, GEM_VALID, BX_SEQ
  );
  modport slave (
    input  RX_DATA, RX_ISK, RX_READY,
    output GEM_DATA, GEM_OVERFLOW, GEM_VALID, BX_SEQ
  );
endinterface

// File: rtl/gem_fiber_err_cnt.sv
// Saturating event counter; a clear in the same cycle as an increment wins.
module gem_fiber_err_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/gem_fiber_rx_deframer.sv
// Aligns the two-word GEM trigger frames, rebuilds the 56-bit cluster payload
// and tracks link lock, bunch-sequence K-codes and error counts.
module gem_fiber_rx_deframer
  import gem_fiber_pkg::*;
#(
  parameter int LOCK_FRAMES = 4,
  parameter int UNLOCK_ERRS = 8,
  parameter int CNT_W       = 16
) (
  input  logic                   TRG_CLK80,
  input  logic                   TRG_RST_N,
  gem_fiber_rx_deframer_if.slave link,
  input  logic                   CNT_CLR,
  output logic                   LOCKED,
  output logic                   LINK_IDLE,
  output logic [CNT_W-1:0]       FRAME_ERR_CNT,
  output logic [CNT_W-1:0]       SEQ_ERR_CNT
);
  localparam int GW = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES) : 1;
  localparam int BW = (UNLOCK_ERRS > 1) ? $clog2(UNLOCK_ERRS) : 1;

  state_e        state_q, state_d;
  logic          phase_q, phase_d;  // 1: word B is due next
  logic [GW-1:0] good_q, good_d;
  logic [BW-1:0] bad_q, bad_d;
  logic [31:0]   a_word_q, a_word_d;
  logic [55:0]   data_q, data_d;
  logic          ovf_q, ovf_d;
  logic          valid_q, valid_d;
  logic          idle_q, idle_d;
  logic [1:0]    bx_q, bx_d;

  logic          word_idle, a_ok, b_ok;
  logic          frame_good, frame_bad, deliver;
  logic          frame_err_inc, seq_err_inc;
  logic [7:0]    sep;
  logic [1:0]    sep_idx;

  assign sep       = link.RX_DATA[7:0];
  assign sep_idx   = k_to_idx(sep);
  assign word_idle = (link.RX_ISK == ISK_IDLE) && (link.RX_DATA == IDLE_WORD);
  assign a_ok      = (link.RX_ISK == ISK_A);
  assign b_ok      = (link.RX_ISK == ISK_B) && is_sep(sep);

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    good_d        = good_q;
    bad_d         = bad_q;
    a_word_d      = a_word_q;
    data_d        = data_q;
    ovf_d         = ovf_q;
    bx_d          = bx_q;
    idle_d        = idle_q;
    valid_d       = 1'b0;
    frame_good    = 1'b0;
    frame_bad     = 1'b0;
    deliver       = 1'b0;
    frame_err_inc = 1'b0;
    seq_err_inc   = 1'b0;

    if (!link.RX_READY) begin
      state_d = ST_HUNT;
      phase_d = 1'b0;
      good_d  = '0;
      bad_d   = '0;
    end else if (word_idle) begin
      idle_d  = 1'b1;
      phase_d = 1'b0;
    end else begin
      idle_d = 1'b0;
      if (state_q == ST_HUNT) begin
        // Any well-formed B word marks a boundary: the next word should be A.
        if (b_ok) begin
          state_d = ST_CHECK;
          phase_d = 1'b0;
          good_d  = '0;
          bad_d   = '0;
        end
      end else if (!phase_q) begin
        if (a_ok) begin
          phase_d  = 1'b1;
          a_word_d = link.RX_DATA;
        end else begin
          frame_bad = 1'b1;
        end
      end else begin
        phase_d    = 1'b0;
        frame_good = b_ok;
        frame_bad  = !b_ok;
      end

      if (frame_bad) begin
        frame_err_inc = 1'b1;
        phase_d       = 1'b0;
        if ((state_q == ST_CHECK) || (bad_q == BW'(UNLOCK_ERRS - 1))) begin
          state_d = ST_HUNT;
          good_d  = '0;
          bad_d   = '0;
        end else begin
          bad_d = bad_q + BW'(1);
        end
      end

      if (frame_good) begin
        if (state_q == ST_LOCKED) begin
          deliver = 1'b1;
          bad_d   = '0;
        end else if (good_q == GW'(LOCK_FRAMES - 1)) begin
          deliver = 1'b1;
          state_d = ST_LOCKED;
          bad_d   = '0;
        end else begin
          good_d = good_q + GW'(1);
        end
      end

      // The frame that completes lock has no trusted predecessor, so it only seeds BX_SEQ.
      if (deliver) begin
        valid_d = 1'b1;
        data_d  = {a_word_q, link.RX_DATA[31:8]};
        if (sep == K_FC) begin
          ovf_d = 1'b1;
          bx_d  = bx_q + 2'd1;
        end else begin
          ovf_d       = 1'b0;
          bx_d        = sep_idx;
          seq_err_inc = (state_q == ST_LOCKED) && (sep_idx != bx_q + 2'd1);
        end
      end
    end
  end

  always_ff @(posedge TRG_CLK80 or negedge TRG_RST_N) begin
    if (!TRG_RST_N) begin
      state_q  <= ST_HUNT;
      phase_q  <= 1'b0;
      good_q   <= '0;
      bad_q    <= '0;
      a_word_q <= '0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      idle_q   <= 1'b0;
      bx_q     <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
      a_word_q <= a_word_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      idle_q   <= idle_d;
      bx_q     <= bx_d;
    end
  end

  gem_fiber_err_cnt #(.CNT_W(CNT_W)) u_frame_err_cnt (
    .clk_i  (TRG_CLK80),
    .rst_ni (TRG_RST_N),
    .inc_i  (frame_err_inc),
    .clr_i  (CNT_CLR),
    .cnt_o  (FRAME_ERR_CNT)
  );

  gem_fiber_err_cnt #(.CNT_W(CNT_W)) u_seq_err_cnt (
    .clk_i  (TRG_CLK80),
    .rst_ni (TRG_RST_N),
    .inc_i  (seq_err_inc),
    .clr_i  (CNT_CLR),
    .cnt_o  (SEQ_ERR_CNT)
  );

  assign link.GEM_DATA     = data_q;
  assign link.GEM_OVERFLOW = ovf_q;
  assign link.GEM_VALID    = valid_q;
  assign link.BX_SEQ       = bx_q;
  assign LOCKED            = (state_q == ST_LOCKED);
  assign LINK_IDLE         = idle_q;
endmodule

// File: tb/tb_gem_fiber_rx_deframer.sv
// Directed bench for gem_fiber_rx_deframer: inputs change 1 time unit after a
// rising edge and outputs are sampled there, reflecting every word already clocked in.
module tb_gem_fiber_rx_deframer;
  import gem_fiber_pkg::*;

  localparam int          CNT_W = 8;  // narrow so saturation is reachable quickly
  localparam logic [31:0] A0    = 32'h12345678;
  localparam logic [23:0] P0    = 24'h9ABCDE;
  localparam logic [55:0] D0    = 56'h123456789ABCDE;

  logic             clk     = 1'b0;
  logic             rst_n   = 1'b0;
  logic             cnt_clr = 1'b0;
  logic             locked, link_idle;
  logic [CNT_W-1:0] frame_err_cnt, seq_err_cnt;
  int               tests_run    = 0;
  int               tests_failed = 0;

  gem_fiber_rx_deframer_if rx ();

  gem_fiber_rx_deframer #(.LOCK_FRAMES(4), .UNLOCK_ERRS(8), .CNT_W(CNT_W)) dut (
    .TRG_CLK80     (clk),
    .TRG_RST_N     (rst_n),
    .link          (rx),
    .CNT_CLR       (cnt_clr),
    .LOCKED        (locked),
    .LINK_IDLE     (link_idle),
    .FRAME_ERR_CNT (frame_err_cnt),
    .SEQ_ERR_CNT   (seq_err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [31:0] d, input logic [3:0] k);
    rx.RX_DATA = d;
    rx.RX_ISK  = k;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [31:0] a, input logic [23:0] p, input logic [7:0] k);
    send(a, ISK_A);
    send({p, k}, ISK_B);
  endtask

  task automatic test_reset();
    rx.RX_READY = 1'b1;
    rx.RX_DATA  = IDLE_WORD;
    rx.RX_ISK   = ISK_IDLE;
    rst_n       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (rx.GEM_DATA !== 56'h0) begin tests_failed++; $display("FAIL reset_data: got %h want 0", rx.GEM_DATA); end
    tests_run++; if ({rx.GEM_OVERFLOW, rx.GEM_VALID, rx.BX_SEQ} !== 4'b0) begin tests_failed++; $display("FAIL reset_ovf_valid_bx: got %b want 0000", {rx.GEM_OVERFLOW, rx.GEM_VALID, rx.BX_SEQ}); end
    tests_run++; if ({locked, link_idle} !== 2'b00) begin tests_failed++; $display("FAIL reset_locked_idle: got %b want 00", {locked, link_idle}); end
    tests_run++; if ({frame_err_cnt, seq_err_cnt} !== '0) begin tests_failed++; $display("FAIL reset_counters: got %0d/%0d want 0/0", frame_err_cnt, seq_err_cnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_lock();
    logic [7:0] ks [4] = '{K_F7, K_FB, K_FD, K_BC};
    logic [1:0] eb [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    repeat (8) send(IDLE_WORD, ISK_IDLE);
    tests_run++; if (link_idle !== 1'b1) begin tests_failed++; $display("FAIL idle_flag: got %b want 1", link_idle); end
    tests_run++; if ({locked, rx.GEM_VALID} !== 2'b00) begin tests_failed++; $display("FAIL idle_no_lock: got %b want 00", {locked, rx.GEM_VALID}); end
    send_frame(A0, P0, K_BC);
    tests_run++; if ({link_idle, locked, rx.GEM_VALID} !== 3'b000) begin tests_failed++; $display("FAIL hunt_frame: idle/locked/valid got %b want 000", {link_idle, locked, rx.GEM_VALID}); end
    for (int i = 0; i < 4; i++) begin
      send_frame(A0, P0, ks[i]);
      tests_run++; if ({locked, rx.GEM_VALID} !== {2{i == 3}}) begin tests_failed++; $display("FAIL check_frame%0d: locked/valid got %b want %b", i, {locked, rx.GEM_VALID}, {2{i == 3}}); end
    end
    tests_run++; if (rx.GEM_DATA !== D0) begin tests_failed++; $display("FAIL lock_data: got %h want %h", rx.GEM_DATA, D0); end
    tests_run++; if ({rx.GEM_OVERFLOW, rx.BX_SEQ} !== 3'b000) begin tests_failed++; $display("FAIL lock_ovf_bx: got %b want 000", {rx.GEM_OVERFLOW, rx.BX_SEQ}); end
    for (int i = 0; i < 4; i++) begin
      send(A0, ISK_A);
      tests_run++; if ({locked, rx.GEM_VALID} !== 2'b10) begin tests_failed++; $display("FAIL strobe_low%0d: locked/valid got %b want 10", i, {locked, rx.GEM_VALID}); end
      send({P0, ks[i]}, ISK_B);
      tests_run++; if ({rx.GEM_VALID, rx.BX_SEQ} !== {1'b1, eb[i]}) begin tests_failed++; $display("FAIL seq_bx%0d: valid/bx got %b want %b", i, {rx.GEM_VALID, rx.BX_SEQ}, {1'b1, eb[i]}); end
      tests_run++; if (rx.GEM_DATA !== D0) begin tests_failed++; $display("FAIL seq_data%0d: got %h want %h", i, rx.GEM_DATA, D0); end
    end
    tests_run++; if ({frame_err_cnt, seq_err_cnt} !== '0) begin tests_failed++; $display("FAIL lock_no_errors: got %0d/%0d want 0/0", frame_err_cnt, seq_err_cnt); end
  endtask

  task automatic test_overflow();
    send_frame(A0, P0, K_F7);
    tests_run++; if ({rx.GEM_OVERFLOW, rx.BX_SEQ} !== 3'b001) begin tests_failed++; $display("FAIL pre_ovf_bx: got %b want 001", {rx.GEM_OVERFLOW, rx.BX_SEQ}); end
    send_frame(32'hCAFEF00D, 24'h123456, K_FC);
    tests_run++; if ({rx.GEM_VALID, rx.GEM_OVERFLOW, rx.BX_SEQ} !== 4'b1110) begin tests_failed++; $display("FAIL ovf_frame: valid/ovf/bx got %b want 1110", {rx.GEM_VALID, rx.GEM_OVERFLOW, rx.BX_SEQ}); end
    tests_run++; if (rx.GEM_DATA !== 56'hCAFEF00D123456) begin tests_failed++; $display("FAIL ovf_data: got %h want cafef00d123456", rx.GEM_DATA); end
    send_frame(A0, P0, K_FD);
    tests_run++; if ({rx.GEM_OVERFLOW, rx.BX_SEQ} !== 3'b011) begin tests_failed++; $display("FAIL post_ovf_bx: got %b want 011", {rx.GEM_OVERFLOW, rx.BX_SEQ}); end
    tests_run++; if (seq_err_cnt !== 8'd0) begin tests_failed++; $display("FAIL ovf_seq_cnt: got %0d want 0", seq_err_cnt); end
  endtask

  task automatic test_seq_error();
    send_frame(A0, P0, K_BC);
    send_frame(A0, P0, K_F7);
    send_frame(A0, P0, K_FD);
    tests_run++; if (seq_err_cnt !== 8'd1) begin tests_failed++; $display("FAIL seq_err_cnt: got %0d want 1", seq_err_cnt); end
    tests_run++; if ({rx.GEM_VALID, rx.BX_SEQ} !== 3'b111) begin tests_failed++; $display("FAIL seq_resync: valid/bx got %b want 111", {rx.GEM_VALID, rx.BX_SEQ}); end
    send_frame(A0, P0, K_BC);
    tests_run++; if ({seq_err_cnt, rx.BX_SEQ} !== {8'd1, 2'd0}) begin tests_failed++; $display("FAIL seq_after_resync: cnt %0d bx %0d want 1 0", seq_err_cnt, rx.BX_SEQ); end
  endtask

  task automatic test_idle_locked();
    send(A0, ISK_A);
    send(IDLE_WORD, ISK_IDLE);
    tests_run++; if ({link_idle, locked, rx.GEM_VALID} !== 3'b110) begin tests_failed++; $display("FAIL idle_locked: idle/locked/valid got %b want 110", {link_idle, locked, rx.GEM_VALID}); end
    send_frame(A0, P0, K_F7);
    tests_run++; if ({link_idle, rx.GEM_VALID, rx.BX_SEQ} !== 4'b0101) begin tests_failed++; $display("FAIL idle_resume: idle/valid/bx got %b want 0101", {link_idle, rx.GEM_VALID, rx.BX_SEQ}); end
    tests_run++; if (frame_err_cnt !== 8'd0) begin tests_failed++; $display("FAIL idle_not_counted: got %0d want 0", frame_err_cnt); end
  endtask

  task automatic test_slip_unlock();
    send({P0, K_FB}, ISK_B);
    tests_run++; if ({frame_err_cnt, locked, rx.GEM_VALID} !== {8'd1, 2'b10}) begin tests_failed++; $display("FAIL slip: cnt %0d locked %b valid %b want 1 1 0", frame_err_cnt, locked, rx.GEM_VALID); end
    send_frame(A0, P0, K_FB);
    tests_run++; if ({locked, rx.GEM_VALID, rx.BX_SEQ} !== 4'b1110) begin tests_failed++; $display("FAIL realign: locked/valid/bx got %b want 1110", {locked, rx.GEM_VALID, rx.BX_SEQ}); end
    for (int i = 0; i < 8; i++) begin
      send({P0, K_BC}, ISK_B);
      tests_run++; if (locked !== (i < 7)) begin tests_failed++; $display("FAIL unlock_run%0d: locked got %b want %b", i, locked, (i < 7)); end
    end
    tests_run++; if (frame_err_cnt !== 8'd9) begin tests_failed++; $display("FAIL unlock_cnt: got %0d want 9", frame_err_cnt); end
    send({P0, K_BC}, ISK_B);
    tests_run++; if ({frame_err_cnt, locked} !== {8'd9, 1'b0}) begin tests_failed++; $display("FAIL hunt_no_count: cnt %0d locked %b want 9 0", frame_err_cnt, locked); end
  endtask

  task automatic test_saturation();
    // From CHECK each pair of B words gives exactly one error and returns to CHECK.
    repeat (10) begin send({P0, K_BC}, ISK_B); send({P0, K_BC}, ISK_B); end
    tests_run++; if (frame_err_cnt !== 8'd19) begin tests_failed++; $display("FAIL cnt_count: got %0d want 19", frame_err_cnt); end
    repeat (251) begin send({P0, K_BC}, ISK_B); send({P0, K_BC}, ISK_B); end
    tests_run++; if (frame_err_cnt !== 8'hFF) begin tests_failed++; $display("FAIL cnt_saturate: got %0d want 255", frame_err_cnt); end
    send({P0, K_BC}, ISK_B); send({P0, K_BC}, ISK_B);
    tests_run++; if (frame_err_cnt !== 8'hFF) begin tests_failed++; $display("FAIL cnt_hold_sat: got %0d want 255", frame_err_cnt); end
    tests_run++; if (seq_err_cnt !== 8'd1) begin tests_failed++; $display("FAIL seq_cnt_kept: got %0d want 1", seq_err_cnt); end
    cnt_clr = 1'b1;
    send({P0, K_BC}, ISK_B);
    cnt_clr = 1'b0;
    tests_run++; if ({frame_err_cnt, seq_err_cnt} !== '0) begin tests_failed++; $display("FAIL clr_wins: got %0d/%0d want 0/0", frame_err_cnt, seq_err_cnt); end
    send({P0, K_BC}, ISK_B); send({P0, K_BC}, ISK_B);
    tests_run++; if (frame_err_cnt !== 8'd1) begin tests_failed++; $display("FAIL cnt_after_clr: got %0d want 1", frame_err_cnt); end
  endtask

  task automatic test_rx_ready();
    logic [7:0] ks [4] = '{K_F7, K_FB, K_FD, K_BC};
    send_frame(A0, P0, K_BC);
    for (int i = 0; i < 4; i++) send_frame(A0, P0, ks[i]);
    tests_run++; if (locked !== 1'b1) begin tests_failed++; $display("FAIL relock_before_ready: got %b want 1", locked); end
    rx.RX_READY = 1'b0;
    send(A0, ISK_A);
    rx.RX_READY = 1'b1;
    tests_run++; if ({locked, rx.GEM_VALID} !== 2'b00) begin tests_failed++; $display("FAIL ready_low: locked/valid got %b want 00", {locked, rx.GEM_VALID}); end
    tests_run++; if ({rx.GEM_DATA, frame_err_cnt} !== {D0, 8'd1}) begin tests_failed++; $display("FAIL ready_hold: data %h cnt %0d want %h 1", rx.GEM_DATA, frame_err_cnt, D0); end
    send_frame(A0, P0, K_BC);
    for (int i = 0; i < 3; i++) begin
      send_frame(A0, P0, ks[i]);
      tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL relock_early%0d: got %b want 0", i, locked); end
    end
    send_frame(32'h0BADBEEF, 24'h55AA33, K_BC);
    tests_run++; if ({locked, rx.GEM_VALID, rx.BX_SEQ} !== 4'b1100) begin tests_failed++; $display("FAIL relock: locked/valid/bx got %b want 1100", {locked, rx.GEM_VALID, rx.BX_SEQ}); end
    tests_run++; if (rx.GEM_DATA !== 56'h0BADBEEF55AA33) begin tests_failed++; $display("FAIL relock_data: got %h want 0badbeef55aa33", rx.GEM_DATA); end
  endtask

  task automatic test_async_reset();
    send(A0, ISK_A);
    #3;
    rst_n = 1'b0;
    #1;
    tests_run++; if (rx.GEM_DATA !== 56'h0) begin tests_failed++; $display("FAIL arst_data: got %h want 0", rx.GEM_DATA); end
    tests_run++; if ({locked, link_idle, rx.GEM_OVERFLOW, rx.GEM_VALID, rx.BX_SEQ} !== 6'b0) begin tests_failed++; $display("FAIL arst_flags: got %b want 000000", {locked, link_idle, rx.GEM_OVERFLOW, rx.GEM_VALID, rx.BX_SEQ}); end
    tests_run++; if (frame_err_cnt !== 8'd0) begin tests_failed++; $display("FAIL arst_cnt: got %0d want 0", frame_err_cnt); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_overflow();
    test_seq_error();
    test_idle_locked();
    test_slip_unlock();
    test_saturation();
    test_rx_ready();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/gem_fiber_rx_deframer.md
# gem_fiber_rx_deframer

Receive-side deframer for the fixed-latency GEM trigger fiber link. Takes the 32-bit/4-bit-K word stream from the GTX receiver at 80 MHz, finds the two-word frame boundary and reassembles the 56-bit S-bit cluster payload and the overflow flag once per bunch crossing. It also checks the BC/F7/FB/FD bunch-sequence K-codes and reports link lock and error counts. It sits between the trigger-link GTX RX wrapper and the cluster consumer/monitoring registers.

## Interface
- LOCK_FRAMES, 4: consecutive good frames required to assert LOCKED
- UNLOCK_ERRS, 8: consecutive bad frames that drop LOCKED
- CNT_W, 16: error counter width
- TRG_CLK80  in  1  80 MHz RX user clock; the only clock
- TRG_RST_N  in  1  reset, asynchronous and active-low
- RX_DATA  in  32  GTX RX data word, byte 0 = [7:0]
- RX_ISK  in  4  GTX RX char-is-K flags, one per byte
- RX_READY  in  1  GTX RX reset done and comma-aligned; low → treated as reset of framing state
- CNT_CLR  in  1  synchronous clear of both error counters
- GEM_DATA  out  56  reassembled payload
- GEM_OVERFLOW  out  1  frame separator was FC
- GEM_VALID  out  1  one-cycle strobe, new frame on GEM_DATA
- BX_SEQ  out  2  received sequence index: BC=0, F7=1, FB=2, FD=3
- LOCKED  out  1  frame alignment locked
- LINK_IDLE  out  1  last received word was the idle/reset pattern
- FRAME_ERR_CNT  out  CNT_W  saturating framing error count
- SEQ_ERR_CNT  out  CNT_W  saturating sequence error count

## Operation
- Frame = word A (ISK 0000, payload [55:24]) followed by word B (ISK 0001, payload [23:0] in [31:8], separator K in [7:0]). GEM_DATA = {A, B[31:8]}.
- Idle word: ISK 0101 and data 32'h50BC50BC. Sets LINK_IDLE, forces phase to "expect A", not counted, LOCKED unchanged, no GEM_VALID. Any non-idle word clears LINK_IDLE.
- Valid separators: BC, F7, FB, FD, FC. FC → GEM_OVERFLOW=1, BX_SEQ = previous+1 (predicted), no sequence check.
- States: HUNT, CHECK, LOCKED.
  - HUNT: on word with ISK 0001 and valid separator → CHECK, phase = expect A, good=0. Nothing emitted.
  - CHECK/LOCKED: expect A then B alternately. A good if ISK 0000; B good if ISK 0001 and valid separator. Any bad word = bad frame: FRAME_ERR_CNT+1, phase forced to expect A.
  - CHECK: LOCK_FRAMES consecutive good frames → LOCKED; bad frame → HUNT.
  - LOCKED: UNLOCK_ERRS consecutive bad frames → HUNT; a good frame resets the bad run.
- GEM_VALID only for good frames in LOCKED (and the frame completing lock). GEM_DATA/GEM_OVERFLOW/BX_SEQ hold between strobes.
- Sequence: in LOCKED, non-FC separator ≠ expected (previous+1 mod 4) → SEQ_ERR_CNT+1, BX_SEQ resynchronises to received value; frame still delivered.
- Counters saturate at all-ones; CNT_CLR wins over simultaneous increment.
- RX_READY low: state → HUNT, phase → expect A, LOCKED=0, data outputs hold, counters hold.

## Timing
- Reset values: GEM_DATA 0, GEM_OVERFLOW 0, GEM_VALID 0, BX_SEQ 0, LOCKED 0, LINK_IDLE 0, counters 0, state HUNT.
- A at cycle n, B at n+1 → GEM_VALID high at n+2, GEM_DATA valid from n+2.
- LOCKED rises at n+2 of the LOCK_FRAMES-th good frame; falls the cycle after the UNLOCK_ERRS-th bad word is registered.
- Counters update the cycle after the offending word.
- Maximum GEM_VALID rate: one per two cycles.

## Structure
- gem_fiber_pkg: K constants (BC, F7, FB, FD, FC), IDLE_WORD 32'h50BC50BC, ISK_A 4'b0000, ISK_B 4'b0001, ISK_IDLE 4'b0101, state enum, K→index function.
- Sub-module gem_fiber_err_cnt (CNT_W, inc, clr, saturating), instantiated twice.

## Test plan
- 8 idle words, then frames A=32'h12345678, B=32'h9ABCDEBC, F7, FB, FD, BC… → LOCKED after 4th frame, GEM_DATA=56'h123456789ABCDE, BX_SEQ 0,1,2,3,0, no errors.
- Locked stream, B separator FC → GEM_OVERFLOW=1, BX_SEQ predicted, SEQ_ERR_CNT unchanged; next frame continues sequence.
- Locked, drop one word (slip phase) → FRAME_ERR_CNT ≥1, realign, LOCKED held; 8 consecutive corrupted frames → LOCKED=0, state HUNT.
- Locked, separator sequence BC,F7,FD → SEQ_ERR_CNT=1, BX_SEQ=3.
- Force 2^CNT_W+5 errors → counter stays at all-ones; CNT_CLR with simultaneous error → 0.
- Async TRG_RST_N low mid-frame → all outputs reset values immediately; RX_READY low 1 cycle → LOCKED=0 next cycle, relock after 4 frames.
